// File: rtl/multi_alarm_unit_pkg.sv
// Shared types, field widths and time-field packing for the multi-channel alarm unit.
package multi_alarm_unit_pkg;

  typedef enum logic [1:0] {
    CH_OFF,
    CH_ARMED,
    CH_RINGING,
    CH_SNOOZED
  } ch_state_t;

  localparam int HOUR_W   = 5;
  localparam int MIN_W    = 6;
  localparam int SEC_W    = 6;
  localparam int TIME_W   = HOUR_W + MIN_W + SEC_W;
  localparam int ALARM_W  = HOUR_W + MIN_W;
  localparam int MAX_HOUR = 23;
  localparam int MAX_MIN  = 59;

  // time_in is {hour, min, sec}; alarm words are {hour, min}
  localparam int SEC_POS        = 0;
  localparam int MIN_POS        = SEC_W;
  localparam int HOUR_POS       = SEC_W + MIN_W;
  localparam int ALARM_MIN_POS  = 0;
  localparam int ALARM_HOUR_POS = MIN_W;

  function automatic int ch_idx_w(input int channels);
    return (channels > 1) ? $clog2(channels) : 1;
  endfunction

  function automatic logic alarm_valid(input logic [ALARM_W-1:0] alarm);
    return (alarm[ALARM_HOUR_POS +: HOUR_W] <= HOUR_W'(MAX_HOUR)) &&
           (alarm[ALARM_MIN_POS +: MIN_W] <= MIN_W'(MAX_MIN));
  endfunction

endpackage

// File: rtl/multi_alarm_unit_if.sv
// Channel-programming bus: a one-cycle write strobe plus the registered reject pulse.
interface multi_alarm_unit_if
  import multi_alarm_unit_pkg::*;
#(
  parameter int CHANNELS = 4
);
  localparam int CW = ch_idx_w(CHANNELS);

  logic               wr_en;
  logic [CW-1:0]      wr_ch;
  logic [ALARM_W-1:0] wr_alarm;
  logic               wr_enable;
  logic               wr_err;

  modport master (
    output wr_en, wr_ch, wr_alarm, wr_enable,
    input  wr_err
  );

  modport slave (
    input  wr_en, wr_ch, wr_alarm, wr_enable,
    output wr_err
  );
endinterface

// File: rtl/multi_alarm_unit_alarm_channel.sv
// One alarm channel: OFF/ARMED/RINGING/SNOOZED FSM, alarm register, saturating
// seconds counter and sticky missed flag.
module alarm_channel
  import multi_alarm_unit_pkg::*;
#(
  parameter int SNOOZE_S       = 300,
  parameter int RING_TIMEOUT_S = 60
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               tick_1s,
  input  logic [TIME_W-1:0]  time_in,
  input  logic               load,
  input  logic [ALARM_W-1:0] load_alarm,
  input  logic               load_enable,
  input  logic               snooze,
  input  logic               stop,
  output logic               ringing,
  output logic               missed
);

  localparam int CNT_TOP = (SNOOZE_S > RING_TIMEOUT_S) ? SNOOZE_S : RING_TIMEOUT_S;
  localparam int CNT_W   = $clog2(CNT_TOP + 1);

  localparam logic [CNT_W-1:0] SNOOZE_LIM = CNT_W'(SNOOZE_S);
  localparam logic [CNT_W-1:0] RING_LIM   = CNT_W'(RING_TIMEOUT_S);
  localparam logic [CNT_W-1:0] CNT_SAT    = '1;

  ch_state_t          state_q, state_d;
  logic [ALARM_W-1:0] alarm_q, alarm_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d, cnt_inc;
  logic               missed_q, missed_d;
  logic               time_match;

  assign cnt_inc = (cnt_q == CNT_SAT) ? cnt_q : cnt_q + 1'b1;

  // Triggering only on second zero keeps a stop inside the alarm minute from retriggering
  assign time_match = tick_1s &&
                      (time_in[HOUR_POS +: HOUR_W] == alarm_q[ALARM_HOUR_POS +: HOUR_W]) &&
                      (time_in[MIN_POS +: MIN_W]   == alarm_q[ALARM_MIN_POS +: MIN_W]) &&
                      (time_in[SEC_POS +: SEC_W]   == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= CH_OFF;
      alarm_q  <= '0;
      cnt_q    <= '0;
      missed_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      alarm_q  <= alarm_d;
      cnt_q    <= cnt_d;
      missed_q <= missed_d;
    end
  end

  // Same-cycle priority: write, then stop, then snooze, then counter expiry, then match
  always_comb begin
    state_d  = state_q;
    alarm_d  = alarm_q;
    cnt_d    = cnt_q;
    missed_d = missed_q;

    if (load) begin
      alarm_d  = load_alarm;
      state_d  = load_enable ? CH_ARMED : CH_OFF;
      cnt_d    = '0;
      missed_d = 1'b0;
    end else if (stop) begin
      missed_d = 1'b0;
      if (state_q == CH_RINGING || state_q == CH_SNOOZED) begin
        state_d = CH_ARMED;
        cnt_d   = '0;
      end
    end else begin
      unique case (state_q)
        CH_ARMED: begin
          if (time_match) begin
            state_d = CH_RINGING;
            cnt_d   = '0;
          end
        end
        CH_RINGING: begin
          if (snooze) begin
            state_d = CH_SNOOZED;
            cnt_d   = '0;
          end else if (tick_1s) begin
            if (cnt_inc >= RING_LIM) begin
              state_d  = CH_ARMED;
              cnt_d    = '0;
              missed_d = 1'b1;
            end else begin
              cnt_d = cnt_inc;
            end
          end
        end
        CH_SNOOZED: begin
          if (tick_1s) begin
            if (cnt_inc >= SNOOZE_LIM) begin
              state_d = CH_RINGING;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_inc;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign ringing = (state_q == CH_RINGING);
  assign missed  = missed_q;

endmodule

// File: rtl/multi_alarm_unit.sv
// Multi-channel alarm unit: write validation and decode, registered reject pulse,
// per-channel alarm instances, ring OR and lowest-index ringing channel.
module multi_alarm_unit
  import multi_alarm_unit_pkg::*;
#(
  parameter int CHANNELS       = 4,
  parameter int SNOOZE_S       = 300,
  parameter int RING_TIMEOUT_S = 60
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                tick_1s,
  input  logic [TIME_W-1:0]   time_in,
  input  logic                snooze,
  input  logic                stop,
  multi_alarm_unit_if.slave   wr_bus,
  output logic                ring,
  output logic [CHANNELS-1:0] ring_vec,
  output logic [ch_idx_w(CHANNELS)-1:0] active_ch,
  output logic [CHANNELS-1:0] missed_vec
);

  localparam int CW = ch_idx_w(CHANNELS);

  logic                ch_ok;
  logic                wr_valid;
  logic [CHANNELS-1:0] load_vec;
  logic                wr_err_q;

  assign ch_ok    = (int'(wr_bus.wr_ch) < CHANNELS);
  assign wr_valid = wr_bus.wr_en && ch_ok && alarm_valid(wr_bus.wr_alarm);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) wr_err_q <= 1'b0;
    else     wr_err_q <= wr_bus.wr_en && !wr_valid;
  end

  assign wr_bus.wr_err = wr_err_q;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    assign load_vec[i] = wr_valid && (wr_bus.wr_ch == CW'(i));

    alarm_channel #(
      .SNOOZE_S       (SNOOZE_S),
      .RING_TIMEOUT_S (RING_TIMEOUT_S)
    ) u_channel (
      .clk         (clk),
      .rst         (rst),
      .tick_1s     (tick_1s),
      .time_in     (time_in),
      .load        (load_vec[i]),
      .load_alarm  (wr_bus.wr_alarm),
      .load_enable (wr_bus.wr_enable),
      .snooze      (snooze),
      .stop        (stop),
      .ringing     (ring_vec[i]),
      .missed      (missed_vec[i])
    );
  end

  assign ring = |ring_vec;

  // Scan downwards so the lowest ringing index is the last one written
  always_comb begin
    active_ch = '0;
    for (int i = CHANNELS - 1; i >= 0; i--) begin
      if (ring_vec[i]) active_ch = CW'(i);
    end
  end

endmodule

// File: tb/tb_multi_alarm_unit.sv
// Directed bench for multi_alarm_unit: expected snapshots are queued with each
// stimulus step and popped for comparison one cycle later.
module tb_multi_alarm_unit;
  import multi_alarm_unit_pkg::*;

  localparam int SNOOZE_S       = 300;
  localparam int RING_TIMEOUT_S = 60;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        tick_1s = 1'b0;
  logic [16:0] time_in = '0;
  logic        snooze = 1'b0;
  logic        stop = 1'b0;

  logic        ring, ring3;
  logic [3:0]  ring_vec, missed_vec;
  logic [1:0]  active_ch, active_ch3;
  logic [2:0]  ring_vec3, missed_vec3;

  int errors = 0;
  int checks = 0;

  typedef struct {
    string      tag;
    logic [3:0] rv;
    logic [3:0] mv;
    logic       werr;
    logic       werr3;
  } exp_t;

  exp_t sb[$];

  multi_alarm_unit_if #(.CHANNELS(4)) bus4 ();
  multi_alarm_unit_if #(.CHANNELS(3)) bus3 ();

  multi_alarm_unit #(
    .CHANNELS(4), .SNOOZE_S(SNOOZE_S), .RING_TIMEOUT_S(RING_TIMEOUT_S)
  ) u_dut (
    .clk(clk), .rst(rst), .tick_1s(tick_1s), .time_in(time_in),
    .snooze(snooze), .stop(stop), .wr_bus(bus4),
    .ring(ring), .ring_vec(ring_vec), .active_ch(active_ch), .missed_vec(missed_vec)
  );

  multi_alarm_unit #(
    .CHANNELS(3), .SNOOZE_S(SNOOZE_S), .RING_TIMEOUT_S(RING_TIMEOUT_S)
  ) u_dut3 (
    .clk(clk), .rst(rst), .tick_1s(tick_1s), .time_in(time_in),
    .snooze(snooze), .stop(stop), .wr_bus(bus3),
    .ring(ring3), .ring_vec(ring_vec3), .active_ch(active_ch3), .missed_vec(missed_vec3)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [16:0] tm(input int h, input int m, input int s);
    return {5'(h), 6'(m), 6'(s)};
  endfunction

  function automatic logic [10:0] alm(input int h, input int m);
    return {5'(h), 6'(m)};
  endfunction

  function automatic logic [1:0] lowIdx(input logic [3:0] rv);
    for (int i = 0; i < 4; i++) if (rv[i]) return 2'(i);
    return 2'd0;
  endfunction

  task automatic expectOut(input string tag, input logic [3:0] rv, input logic [3:0] mv,
                           input logic werr, input logic werr3 = 1'b0);
    exp_t e;
    e.tag = tag; e.rv = rv; e.mv = mv; e.werr = werr; e.werr3 = werr3;
    sb.push_back(e);
  endtask

  task automatic checkOutput();
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("[TB] FAIL scoreboard: empty queue, got 0 entries required 1");
      return;
    end
    e = sb.pop_front();
    checks++;
    assert (ring_vec === e.rv) else begin
      errors++; $error("[TB] FAIL %s ring_vec: got %b required %b", e.tag, ring_vec, e.rv);
    end
    checks++;
    assert (ring === (|e.rv)) else begin
      errors++; $error("[TB] FAIL %s ring: got %b required %b", e.tag, ring, |e.rv);
    end
    checks++;
    assert (active_ch === lowIdx(e.rv)) else begin
      errors++; $error("[TB] FAIL %s active_ch: got %0d required %0d", e.tag, active_ch, lowIdx(e.rv));
    end
    checks++;
    assert (missed_vec === e.mv) else begin
      errors++; $error("[TB] FAIL %s missed_vec: got %b required %b", e.tag, missed_vec, e.mv);
    end
    checks++;
    assert (bus4.wr_err === e.werr) else begin
      errors++; $error("[TB] FAIL %s wr_err: got %b required %b", e.tag, bus4.wr_err, e.werr);
    end
    checks++;
    assert (bus3.wr_err === e.werr3) else begin
      errors++; $error("[TB] FAIL %s wr_err3: got %b required %b", e.tag, bus3.wr_err, e.werr3);
    end
    checks++;
    assert (ring_vec3 === 3'b000) else begin
      errors++; $error("[TB] FAIL %s ring_vec3: got %b required 000", e.tag, ring_vec3);
    end
  endtask

  // One clock of stimulus: drive at negedge, release pulses 1 time unit after posedge
  task automatic applyStimulus(input logic tk, input logic [16:0] t, input logic we,
                               input logic [1:0] ch, input logic [10:0] a, input logic en,
                               input logic snz, input logic stp);
    @(negedge clk);
    tick_1s = tk; time_in = t;
    bus4.wr_en = we; bus4.wr_ch = ch; bus4.wr_alarm = a; bus4.wr_enable = en;
    snooze = snz; stop = stp;
    @(posedge clk);
    #1;
    tick_1s = 1'b0; bus4.wr_en = 1'b0; snooze = 1'b0; stop = 1'b0; bus3.wr_en = 1'b0;
  endtask

  task automatic doTick(input logic [16:0] t);
    applyStimulus(1'b1, t, 1'b0, 2'd0, 11'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic doWrite(input logic [1:0] ch, input logic [10:0] a, input logic en);
    applyStimulus(1'b0, time_in, 1'b1, ch, a, en, 1'b0, 1'b0);
  endtask

  task automatic doCtrl(input logic snz, input logic stp);
    applyStimulus(1'b0, time_in, 1'b0, 2'd0, 11'd0, 1'b0, snz, stp);
  endtask

  initial begin
    bus4.wr_en = 1'b0; bus4.wr_ch = '0; bus4.wr_alarm = '0; bus4.wr_enable = 1'b0;
    bus3.wr_en = 1'b0; bus3.wr_ch = '0; bus3.wr_alarm = '0; bus3.wr_enable = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    expectOut("reset", 4'b0000, 4'b0000, 1'b0);
    checkOutput();
    @(negedge clk);
    rst = 1'b0;

    // ch2 at 07:30, ring on the second-zero tick
    doWrite(2'd2, alm(7, 30), 1'b1);
    expectOut("wr_ch2", 4'b0000, 4'b0000, 1'b0); checkOutput();
    doTick(tm(7, 29, 59));
    expectOut("pre_match", 4'b0000, 4'b0000, 1'b0); checkOutput();
    doTick(tm(7, 30, 0));
    expectOut("match_ch2", 4'b0100, 4'b0000, 1'b0); checkOutput();

    // Snooze; a time match during snooze must not restart anything
    doCtrl(1'b1, 1'b0);
    expectOut("snooze_ch2", 4'b0000, 4'b0000, 1'b0); checkOutput();
    for (int k = 1; k <= SNOOZE_S; k++) begin
      doTick((k == 1) ? tm(7, 30, 0) : tm(7, 31 + k / 60, k % 60));
      expectOut("snooze_tick", (k == SNOOZE_S) ? 4'b0100 : 4'b0000, 4'b0000, 1'b0);
      checkOutput();
    end
    doCtrl(1'b0, 1'b1);
    expectOut("stop_ch2", 4'b0000, 4'b0000, 1'b0); checkOutput();

    // ch1 at 08:00 rings unattended until timeout
    doWrite(2'd1, alm(8, 0), 1'b1);
    expectOut("wr_ch1", 4'b0000, 4'b0000, 1'b0); checkOutput();
    doTick(tm(8, 0, 0));
    expectOut("match_ch1", 4'b0010, 4'b0000, 1'b0); checkOutput();
    for (int k = 1; k <= RING_TIMEOUT_S; k++) begin
      doTick((k < 60) ? tm(8, 0, k) : tm(8, 1, 0));
      expectOut("ring_timeout", (k == RING_TIMEOUT_S) ? 4'b0000 : 4'b0010,
                (k == RING_TIMEOUT_S) ? 4'b0010 : 4'b0000, 1'b0);
      checkOutput();
    end
    doCtrl(1'b0, 1'b1);
    expectOut("stop_clr_missed", 4'b0000, 4'b0000, 1'b0); checkOutput();

    // Rejected writes: bad minute, bad hour, and out-of-range channel on a 3-channel unit
    doWrite(2'd1, alm(8, 60), 1'b0);
    expectOut("bad_min", 4'b0000, 4'b0000, 1'b1); checkOutput();
    doWrite(2'd2, alm(24, 30), 1'b0);
    expectOut("bad_hour", 4'b0000, 4'b0000, 1'b1); checkOutput();
    bus3.wr_en = 1'b1; bus3.wr_ch = 2'd3; bus3.wr_alarm = alm(7, 30); bus3.wr_enable = 1'b1;
    doCtrl(1'b0, 1'b0);
    expectOut("bad_ch", 4'b0000, 4'b0000, 1'b0, 1'b1); checkOutput();
    doCtrl(1'b0, 1'b0);
    expectOut("err_once", 4'b0000, 4'b0000, 1'b0, 1'b0); checkOutput();
    doTick(tm(8, 0, 0));
    expectOut("ch1_intact", 4'b0010, 4'b0000, 1'b0); checkOutput();
    doCtrl(1'b0, 1'b1);
    expectOut("stop_ch1", 4'b0000, 4'b0000, 1'b0); checkOutput();
    doTick(tm(7, 30, 0));
    expectOut("ch2_intact", 4'b0100, 4'b0000, 1'b0); checkOutput();
    doCtrl(1'b0, 1'b1);
    expectOut("stop_ch2b", 4'b0000, 4'b0000, 1'b0); checkOutput();

    // ch0 and ch3 share 06:00; stop with snooze wins, no retrigger on sec != 0
    doWrite(2'd0, alm(6, 0), 1'b1);
    expectOut("wr_ch0", 4'b0000, 4'b0000, 1'b0); checkOutput();
    doWrite(2'd3, alm(6, 0), 1'b1);
    expectOut("wr_ch3", 4'b0000, 4'b0000, 1'b0); checkOutput();
    doTick(tm(6, 0, 0));
    expectOut("match_ch0_ch3", 4'b1001, 4'b0000, 1'b0); checkOutput();
    doCtrl(1'b1, 1'b1);
    expectOut("stop_snooze", 4'b0000, 4'b0000, 1'b0); checkOutput();
    for (int s = 1; s <= 5; s++) begin
      doTick(tm(6, 0, s));
      expectOut("no_retrigger", 4'b0000, 4'b0000, 1'b0); checkOutput();
    end

    // Asynchronous reset while ringing
    doTick(tm(6, 0, 0));
    expectOut("rering", 4'b1001, 4'b0000, 1'b0); checkOutput();
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    expectOut("async_rst", 4'b0000, 4'b0000, 1'b0); checkOutput();
    @(negedge clk);
    rst = 1'b0;
    doTick(tm(6, 0, 0));
    expectOut("post_rst_0600", 4'b0000, 4'b0000, 1'b0); checkOutput();
    doTick(tm(7, 30, 0));
    expectOut("post_rst_0730", 4'b0000, 4'b0000, 1'b0); checkOutput();
    doTick(tm(0, 0, 0));
    expectOut("post_rst_0000", 4'b0000, 4'b0000, 1'b0); checkOutput();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/multi_alarm_unit.md
MULTI_ALARM_UNIT -- requirements
Module: multi_alarm_unit

Interface
REQ-001 Parameter CHANNELS, 4, number of independent alarm channels (1..16).
REQ-002 Parameter SNOOZE_S, 300, snooze duration in seconds (>=1).
REQ-003 Parameter RING_TIMEOUT_S, 60, seconds of ringing before auto-stop (>=1).
REQ-004 Localparam CW = max(1, clog2(CHANNELS)), channel index width.
REQ-005 clk  input  1  system clock.
REQ-006 rst  input  1  reset, asynchronous, active-high.
REQ-007 tick_1s  input  1  one-clk-cycle pulse per second, synchronous to clk.
REQ-008 time_in  input  17  current time {hour[4:0], min[5:0], sec[5:0]}, binary.
REQ-009 wr_en  input  1  one-cycle write strobe for channel programming.
REQ-010 wr_ch  input  CW  channel index being written.
REQ-011 wr_alarm  input  11  alarm time {hour[4:0], min[5:0]}.
REQ-012 wr_enable  input  1  1 = arm channel, 0 = disable channel.
REQ-013 snooze  input  1  one-cycle pulse, snooze all ringing channels.
REQ-014 stop  input  1  one-cycle pulse, stop all ringing/snoozed channels.
REQ-015 ring  output  1  OR of all channels in RINGING.
REQ-016 ring_vec  output  CHANNELS  per-channel RINGING flag.
REQ-017 active_ch  output  CW  lowest-index ringing channel; 0 when none.
REQ-018 missed_vec  output  CHANNELS  sticky per-channel flag: channel timed out unattended.
REQ-019 wr_err  output  1  one-cycle pulse: write rejected.

Function
REQ-020 Each channel SHALL hold an FSM with states OFF, ARMED, RINGING, SNOOZED, an 11-bit alarm register and a seconds counter of width clog2(max(SNOOZE_S, RING_TIMEOUT_S)+1).
REQ-021 Write with wr_ch < CHANNELS, hour <= 23, min <= 59: alarm register loaded; state -> ARMED if wr_enable else OFF; counter cleared; missed flag cleared; takes effect on the clk edge sampling wr_en.
REQ-022 Write with wr_ch >= CHANNELS or hour > 23 or min > 59: no state change; wr_err high exactly the following cycle.
REQ-023 ARMED -> RINGING on a cycle where tick_1s=1, time_in hour/min equal the alarm register and time_in sec = 0; ring_vec bit high the next cycle; counter cleared.
REQ-024 RINGING: counter increments per tick_1s; when it reaches RING_TIMEOUT_S -> ARMED, missed bit set.
REQ-025 snooze while RINGING -> SNOOZED, counter cleared; snooze ignored in other states.
REQ-026 SNOOZED: counter increments per tick_1s; reaching SNOOZE_S -> RINGING, counter cleared, no time match required.
REQ-027 stop while RINGING or SNOOZED -> ARMED, counter cleared, missed bit cleared; ignored in OFF/ARMED except missed clear.
REQ-028 Priority per channel, same cycle: valid write > stop > snooze > timeout/expiry > time match.
REQ-029 A time match while RINGING or SNOOZED SHALL be ignored (no restart of counters).
REQ-030 Because matching requires sec = 0, a stop within the alarm minute SHALL NOT retrigger; next trigger is 24 h later.
REQ-031 All outputs registered except ring and active_ch, which are combinational from ring_vec.
REQ-032 Counters SHALL saturate, never wrap.

Reset
REQ-033 On rst: all channels OFF, alarm registers 0, counters 0, ring_vec 0, missed_vec 0, wr_err 0; ring 0, active_ch 0.
REQ-034 Reset asserted mid-ring SHALL drop ring asynchronously; after release no channel rings until rewritten and matched.

Structure
REQ-035 Shared package holds: channel state enum, field widths (HOUR_W=5, MIN_W=6, SEC_W=6), limits MAX_HOUR=23, MAX_MIN=59, and time-field packing positions.
REQ-036 One sub-module alarm_channel (FSM, alarm register, counter, missed flag) SHALL be instantiated CHANNELS times by generate; top holds write decode/validation, wr_err, OR reduction and lowest-index priority encoder.

Verification
REQ-037 Write ch2 = 07:30 enabled; drive time 07:30:00 with tick_1s -> ring_vec=0100, ring=1, active_ch=2 next cycle.
REQ-038 Ringing ch2, snooze pulse; apply SNOOZE_S ticks -> ring 0 during snooze, ring_vec[2]=1 after tick SNOOZE_S.
REQ-039 Ringing ch1, no user input for RING_TIMEOUT_S ticks -> ring_vec[1]=0, missed_vec[1]=1; subsequent stop clears missed_vec[1].
REQ-040 Write hour=24 or min=60 or wr_ch=CHANNELS -> wr_err pulses once, all channel states unchanged.
REQ-041 ch0 and ch3 both 06:00, match -> ring_vec=1001, active_ch=0; stop and snooze same cycle -> both ARMED, ring=0; holding 06:00:xx, sec!=0 ticks -> no retrigger.
REQ-042 rst asserted between clk edges while ringing -> ring=0 immediately, missed_vec=0, all channels OFF.
